rs232_rx_ctrl: RTL and testbench

//  Receive-side controller for the 8-bit RS232 receiver: acknowledges each received byte,

---
 rtl/rs232_rx_ctrl_pkg.sv | 8 +
 rtl/rs232_rx_ctrl_if.sv | 23 ++
 rtl/rs232_rx_ctrl_rx_fifo.sv | 42 ++++
 rtl/rs232_rx_ctrl.sv | 48 ++++
 tb/tb_rs232_rx_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rs232_rx_ctrl_pkg.sv
// rs232_rx_ctrl_pkg: shared sizes, control-bit indices and ack FSM encoding
package rs232_rx_ctrl_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF = 4;
  localparam int CTRL_FSEL = 0;
  localparam int CTRL_FLUSH = 1;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
endpackage

// File: rtl/rs232_rx_ctrl_if.sv
// rs232_rx_ctrl_if: receiver handshake and CPU register signals of the rx controller
interface rs232_rx_ctrl_if import rs232_rx_ctrl_pkg::*; #(parameter int AW = AW_DEF);
  logic rx_rdy;
  logic [7:0] rx_data;
  logic rx_done;
  logic rx_fsel;
  logic rd;
  logic wr_ctrl;
  logic [1:0] wdata;
  logic [7:0] dout;
  logic avail;
  logic full;
  logic overrun;
  logic [AW:0] count;
  modport master (
    output rx_rdy, rx_data, rd, wr_ctrl, wdata,
    input rx_done, rx_fsel, dout, avail, full, overrun, count
  );
  modport slave (
    input rx_rdy, rx_data, rd, wr_ctrl, wdata,
    output rx_done, rx_fsel, dout, avail, full, overrun, count
  );
endinterface

// File: rtl/rs232_rx_ctrl_rx_fifo.sv
// rx_fifo: synchronous byte FIFO with push/pop/flush; a pop on full frees the slot for a same-edge push
module rx_fifo import rs232_rx_ctrl_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [AW:0] count,
  output logic full,
  output logic empty
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/rs232_rx_ctrl.sv
// rs232_rx_ctrl: acknowledges receiver bytes, buffers them in rx_fifo, tracks overrun and baud select
module rs232_rx_ctrl import rs232_rx_ctrl_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic rst,
  rs232_rx_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic fsel, ovr, flush, take, full, empty;
  assign flush = bus.wr_ctrl && bus.wdata[CTRL_FLUSH];
  assign take = state == IDLE && bus.rx_rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = take ? ACK : IDLE;
  end
  // A byte is lost only when full and no same-edge read frees a slot; flush overrides both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsel <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (bus.wr_ctrl) fsel <= bus.wdata[CTRL_FSEL];
      if (flush) ovr <= 1'b0;
      else if (take && full && !(bus.rd && !empty)) ovr <= 1'b1;
    end
  end
  rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(take),
    .pop(bus.rd),
    .flush(flush),
    .din(bus.rx_data),
    .dout(bus.dout),
    .count(bus.count),
    .full(full),
    .empty(empty)
  );
  assign bus.rx_done = state == ACK;
  assign bus.rx_fsel = fsel;
  assign bus.full = full;
  assign bus.avail = !empty;
  assign bus.overrun = ovr;
endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// tb_rs232_rx_ctrl: directed self-checking bench for rs232_rx_ctrl
module tb_rs232_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  rs232_rx_ctrl_if #(.AW(AW)) bus ();
  rs232_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_rdy = 1'b1;
    bus.rx_data = b;
    cyc();
    bus.rx_rdy = 1'b0;
    cyc();
  endtask

  task automatic pop;
    bus.rd = 1'b1;
    cyc();
    bus.rd = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", bus.rx_done); end
    tests++; if (bus.rx_fsel !== 1'b0) begin fails++; $display("FAIL rst_fsel got %b exp 0", bus.rx_fsel); end
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL rst_avail got %b exp 0", bus.avail); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", bus.full); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun got %b exp 0", bus.overrun); end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'hA5;
    cyc();
    tests++; if (bus.rx_done !== 1'b1) begin fails++; $display("FAIL single_done got %b exp 1", bus.rx_done); end
    tests++; if (bus.avail !== 1'b1) begin fails++; $display("FAIL single_avail got %b exp 1", bus.avail); end
    tests++; if (bus.dout !== 8'hA5) begin fails++; $display("FAIL single_dout got %h exp a5", bus.dout); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL single_count got %0d exp 1", bus.count); end
    bus.rx_rdy = 1'b0;
    cyc();
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL single_done_low got %b exp 0", bus.rx_done); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL single_once got %0d exp 1", bus.count); end
    pop();
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL single_rd_avail got %b exp 0", bus.avail); end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL single_rd_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) send(8'(i));
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", bus.full); end
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL fill_count got %0d exp 16", bus.count); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL fill_ovr got %b exp 0", bus.overrun); end
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'hFF;
    cyc();
    tests++; if (bus.rx_done !== 1'b1) begin fails++; $display("FAIL drop_done got %b exp 1", bus.rx_done); end
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL drop_ovr got %b exp 1", bus.overrun); end
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL drop_count got %0d exp 16", bus.count); end
    bus.rx_rdy = 1'b0;
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      tests++; if (bus.dout !== 8'(i)) begin fails++; $display("FAIL fill_rd[%0d] got %h exp %h", i, bus.dout, 8'(i)); end
      pop();
    end
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL fill_drained got %b exp 0", bus.avail); end
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun); end
  endtask

  task automatic test_control;
    bus.wr_ctrl = 1'b1;
    bus.wdata = 2'b01;
    cyc();
    bus.wr_ctrl = 1'b0;
    tests++; if (bus.rx_fsel !== 1'b1) begin fails++; $display("FAIL ctrl_fsel got %b exp 1", bus.rx_fsel); end
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
    tests++; if (bus.count !== 5'd5) begin fails++; $display("FAIL ctrl_count5 got %0d exp 5", bus.count); end
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h77;
    bus.wr_ctrl = 1'b1;
    bus.wdata = 2'b10;
    cyc();
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL flush_avail got %b exp 0", bus.avail); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL flush_ovr got %b exp 0", bus.overrun); end
    tests++; if (bus.rx_fsel !== 1'b0) begin fails++; $display("FAIL flush_fsel got %b exp 0", bus.rx_fsel); end
    tests++; if (bus.rx_done !== 1'b1) begin fails++; $display("FAIL flush_done got %b exp 1", bus.rx_done); end
    bus.rx_rdy = 1'b0;
    bus.wr_ctrl = 1'b0;
    bus.wdata = 2'b00;
    cyc();
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i));
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL sim_full got %b exp 1", bus.full); end
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h55;
    bus.rd = 1'b1;
    cyc();
    bus.rx_rdy = 1'b0;
    bus.rd = 1'b0;
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL sim_count got %0d exp 16", bus.count); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL sim_ovr got %b exp 0", bus.overrun); end
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'h55;
      tests++; if (bus.dout !== exp) begin fails++; $display("FAIL sim_rd[%0d] got %h exp %h", i, bus.dout, exp); end
      pop();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      exp = 8'((i * 7 + 3) & 8'hFF);
      send(exp);
      tests++; if (bus.dout !== exp) begin fails++; $display("FAIL wrap[%0d] got %h exp %h", i, bus.dout, exp); end
      pop();
    end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL wrap_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_empty_pop;
    bus.rd = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.rd = 1'b0;
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL epop_count got %0d exp 0", bus.count); end
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL epop_avail got %b exp 0", bus.avail); end
    send(8'h3C);
    tests++; if (bus.dout !== 8'h3C) begin fails++; $display("FAIL epop_dout got %h exp 3c", bus.dout); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL epop_count1 got %0d exp 1", bus.count); end
    pop();
  endtask

  task automatic test_reset_mid_byte;
    bus.wr_ctrl = 1'b1;
    bus.wdata = 2'b01;
    cyc();
    bus.wr_ctrl = 1'b0;
    bus.wdata = 2'b00;
    bus.rx_rdy = 1'b1;
    bus.rx_data = 8'h9A;
    cyc();
    tests++; if (bus.rx_done !== 1'b1) begin fails++; $display("FAIL mid_done got %b exp 1", bus.rx_done); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL mid_rst_done got %b exp 0", bus.rx_done); end
    tests++; if (bus.rx_fsel !== 1'b0) begin fails++; $display("FAIL mid_rst_fsel got %b exp 0", bus.rx_fsel); end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL mid_rst_count got %0d exp 0", bus.count); end
    tests++; if (bus.avail !== 1'b0) begin fails++; $display("FAIL mid_rst_avail got %b exp 0", bus.avail); end
    #2 rst = 1'b0;
    cyc();
    tests++; if (bus.rx_done !== 1'b1) begin fails++; $display("FAIL post_done got %b exp 1", bus.rx_done); end
    tests++; if (bus.dout !== 8'h9A) begin fails++; $display("FAIL post_dout got %h exp 9a", bus.dout); end
    bus.rx_rdy = 1'b0;
    cyc();
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL post_once got %0d exp 1", bus.count); end
    tests++; if (bus.rx_done !== 1'b0) begin fails++; $display("FAIL post_done_low got %b exp 0", bus.rx_done); end
  endtask

  initial begin
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd = 1'b0;
    bus.wr_ctrl = 1'b0;
    bus.wdata = 2'b00;
    test_reset();
    test_single();
    test_fill();
    test_control();
    test_simultaneous();
    test_empty_pop();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
